// File: rtl/ps2_voice_allocator_pkg.sv
// Shared constants and helpers for the PS/2 piano voice allocator.
// Note codes 1..98 are playable, 0 means silent, and codes from 99 up are invalid.
package ps2_voice_allocator_pkg;

    localparam int NOTE_W = 8;
    localparam logic [NOTE_W-1:0] NOTE_NONE = '0;
    localparam logic [NOTE_W-1:0] NOTE_STOP = NOTE_W'(99);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ALLOC,
        OP_FREE,
        OP_CLEAR
    } rank_op_e;

    function automatic logic note_is_valid(input logic [NOTE_W-1:0] n);
        return (n != NOTE_NONE) && (n < NOTE_STOP);
    endfunction

endpackage

// File: rtl/ps2_voice_allocator_if.sv
// Bundles the key-event input and the voice outputs of the allocator.
// The decoder side uses the master modport and the allocator uses the slave modport.
interface ps2_voice_allocator_if #(
    parameter int VOICES = 4
) ();
    import ps2_voice_allocator_pkg::*;

    logic                     iEvtValid;
    logic                     iEvtRelease;
    logic [NOTE_W-1:0]        iEvtNote;
    logic                     iAllOff;
    logic [VOICES*NOTE_W-1:0] oVoiceNote;
    logic [VOICES-1:0]        oVoiceActive;
    logic                     oSteal;

    modport master (
        output iEvtValid, iEvtRelease, iEvtNote, iAllOff,
        input  oVoiceNote, oVoiceActive, oSteal
    );

    modport slave (
        input  iEvtValid, iEvtRelease, iEvtNote, iAllOff,
        output oVoiceNote, oVoiceActive, oSteal
    );
endinterface

// File: rtl/ps2_voice_allocator_rank_tracker.sv
// Tracks voice age ranks: 0 is the newest active voice and count-1 is the oldest.
// Inactive voices always hold rank 0. When every voice is busy, one voice holds rank VOICES-1.
module ps2_voice_allocator_rank_tracker
    import ps2_voice_allocator_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int IDX_W  = $clog2(VOICES)
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  rank_op_e          i_op,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [VOICES-1:0] i_active,
    output logic [IDX_W-1:0]  o_oldest
);

    logic [VOICES-1:0][IDX_W-1:0] r_rank;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_rank <= '0;
        end else begin
            case (i_op)
                OP_CLEAR: r_rank <= '0;
                // A steal reuses the oldest slot, so it also follows this path.
                OP_ALLOC: begin
                    for (int v = 0; v < VOICES; v++) begin
                        if (IDX_W'(v) == i_idx)
                            r_rank[v] <= '0;
                        else if (i_active[v])
                            r_rank[v] <= r_rank[v] + IDX_W'(1);
                    end
                end
                OP_FREE: begin
                    for (int v = 0; v < VOICES; v++) begin
                        if (IDX_W'(v) == i_idx)
                            r_rank[v] <= '0;
                        else if (i_active[v] && (r_rank[v] > r_rank[i_idx]))
                            r_rank[v] <= r_rank[v] - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_oldest = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (i_active[v] && (r_rank[v] == IDX_W'(VOICES - 1)))
                o_oldest = IDX_W'(v);
        end
    end

endmodule

// File: rtl/ps2_voice_allocator.sv
// Assigns PS/2 key events to tone-generator voices.
// It allocates free voices, releases voices on key up, and steals the oldest voice when all are busy.
module ps2_voice_allocator
    import ps2_voice_allocator_pkg::*;
#(
    parameter int VOICES = 4
) (
    input logic                 iClk,
    input logic                 iReset_n,
    ps2_voice_allocator_if.slave bus
);

    localparam int IDX_W = $clog2(VOICES);

    logic [VOICES-1:0][NOTE_W-1:0] r_note;
    logic [VOICES-1:0]             r_active;
    logic                          r_steal;

    logic             w_valid, w_hit, w_any_free, w_press, w_release;
    logic [IDX_W-1:0] w_hit_idx, w_free_idx, w_oldest, w_tgt, w_idx;
    rank_op_e         w_op;

    assign w_valid = bus.iEvtValid && !bus.iAllOff && note_is_valid(bus.iEvtNote);

    // A note can be held by at most one voice, so the hit index is unique.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int v = 0; v < VOICES; v++) begin
            if (r_active[v] && (r_note[v] == bus.iEvtNote)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(v);
            end
        end
    end

    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (!r_active[v]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(v);
            end
        end
    end

    assign w_press   = w_valid && !bus.iEvtRelease && !w_hit;
    assign w_release = w_valid &&  bus.iEvtRelease &&  w_hit;
    assign w_tgt     = w_any_free ? w_free_idx : w_oldest;
    assign w_idx     = w_press ? w_tgt : w_hit_idx;

    always_comb begin
        w_op = OP_NONE;
        if (bus.iAllOff)  w_op = OP_CLEAR;
        else if (w_press) w_op = OP_ALLOC;
        else if (w_release) w_op = OP_FREE;
    end

    ps2_voice_allocator_rank_tracker #(.VOICES(VOICES), .IDX_W(IDX_W)) u_rank (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .i_op     (w_op),
        .i_idx    (w_idx),
        .i_active (r_active),
        .o_oldest (w_oldest)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_note   <= '0;
            r_active <= '0;
            r_steal  <= 1'b0;
        end else begin
            r_steal <= w_press && !w_any_free;
            if (bus.iAllOff) begin
                r_note   <= '0;
                r_active <= '0;
            end else if (w_press) begin
                r_note[w_tgt]   <= bus.iEvtNote;
                r_active[w_tgt] <= 1'b1;
            end else if (w_release) begin
                r_note[w_hit_idx]   <= NOTE_NONE;
                r_active[w_hit_idx] <= 1'b0;
            end
        end
    end

    assign bus.oVoiceNote   = r_note;
    assign bus.oVoiceActive = r_active;
    assign bus.oSteal       = r_steal;

endmodule
